// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, the IF/ID pipeline register and the
// BOOT/RUN/HALTED/FAULT sequencing, with redirect, flush, stall and halt control.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  instruction_addr,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [1:0]  state,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 10;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic              r_valid;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_pc4;
  logic [XLEN-1:0]   r_if_instr;
  logic              r_fault;
  logic [XLEN-1:0]   r_fault_pc;
  logic [XLEN-1:0]   r_fetch_count;

  logic              w_misaligned;
  logic              w_take_fault;
  logic [XLEN-1:0]   w_pc_plus4;

  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_take_fault = w_misaligned && (r_state != S_FAULT);
  assign w_pc_plus4   = r_pc + XLEN'(4);

  // A misaligned redirect outranks everything else; FAULT is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_valid       <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc4      <= '0;
      r_if_instr    <= '0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
      r_fetch_count <= '0;
    end else if (w_take_fault) begin
      r_state    <= S_FAULT;
      r_fault    <= 1'b1;
      r_fault_pc <= redirect_pc;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_valid <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
            if (halt_req) r_state <= S_HALTED;
          end else if (halt_req) begin
            r_valid <= 1'b0;
            r_state <= S_HALTED;
          end else if (flush) begin
            r_valid <= 1'b0;
            if (!stall) r_pc <= w_pc_plus4;
          end else if (!stall) begin
            r_valid       <= 1'b1;
            r_if_pc       <= r_pc;
            r_if_pc4      <= w_pc_plus4;
            r_if_instr    <= instruction;
            r_pc          <= w_pc_plus4;
            r_fetch_count <= r_fetch_count + XLEN'(1);
          end
        end
        S_HALTED: begin
          r_valid <= 1'b0;
          if (redirect_valid) r_pc <= redirect_pc;
          if (resume && !halt_req) r_state <= S_RUN;
        end
        S_FAULT: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instruction_addr = r_pc[AW+1:2];
  assign if_id_valid      = r_valid;
  assign if_id_pc         = r_if_pc;
  assign if_id_pc_plus4   = r_if_pc4;
  assign if_id_instr      = r_if_instr;
  assign state            = r_state;
  assign fault            = r_fault;
  assign fault_pc         = r_fault_pc;
  assign fetch_count      = r_fetch_count;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: fetched IF/ID contents are predicted into a
// scoreboard queue when a fetch is expected and popped when the DUT loads IF/ID.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  instruction_addr;
  logic [31:0] instruction;
  logic        stall, flush, redirect_valid, halt_req, resume;
  logic [31:0] redirect_pc;
  logic        if_id_valid, fault;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr, fault_pc, fetch_count;
  logic [1:0]  state;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] exp_count = 32'h0;

  localparam logic [1:0] ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2, ST_FAULT = 2'd3;

  function automatic logic [31:0] instr_of(input logic [9:0] a);
    return 32'hC0DE_0000 ^ ({22'h0, a} * 32'h0001_0101);
  endfunction

  assign instruction = instr_of(instruction_addr);

  always #5 clk = ~clk;

  ifetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_addr(instruction_addr), .instruction(instruction),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .state(state), .fault(fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  task automatic clear_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 32'h0; halt_req = 0; resume = 0;
  endtask

  // One clock: predict a fetch if asked, then check valid, state, PC address and count.
  task automatic tick(input bit push, input bit exp_valid, input logic [1:0] exp_state);
    exp_t e;
    if (push) begin
      sb.push_back('{pc: exp_pc, pc4: exp_pc + 32'd4, instr: instr_of(exp_pc[11:2])});
      exp_pc    = exp_pc + 32'd4;
      exp_count = exp_count + 32'd1;
    end
    @(posedge clk); #1;
    checks++;
    if (if_id_valid !== exp_valid) begin
      failures++; $display("FAIL valid: got %0b expected %0b", if_id_valid, exp_valid);
    end
    checks++;
    if (state !== exp_state) begin
      failures++; $display("FAIL state: got %0d expected %0d", state, exp_state);
    end
    checks++;
    if (instruction_addr !== exp_pc[11:2]) begin
      failures++; $display("FAIL instr_addr: got %0h expected %0h", instruction_addr, exp_pc[11:2]);
    end
    checks++;
    if (fetch_count !== exp_count) begin
      failures++; $display("FAIL fetch_count: got %0d expected %0d", fetch_count, exp_count);
    end
    if (push) begin
      e = sb.pop_front();
      checks++;
      if ({if_id_pc, if_id_pc_plus4, if_id_instr} !== {e.pc, e.pc4, e.instr}) begin
        failures++;
        $display("FAIL ifid: got pc=%0h pc4=%0h instr=%0h expected pc=%0h pc4=%0h instr=%0h",
                 if_id_pc, if_id_pc_plus4, if_id_instr, e.pc, e.pc4, e.instr);
      end
    end
  endtask

  task automatic check_ifid_pc(input logic [31:0] exp);
    checks++;
    if (if_id_pc !== exp) begin
      failures++; $display("FAIL ifid_hold: got %0h expected %0h", if_id_pc, exp);
    end
  endtask

  // Reset is asserted between edges and checked before any further clock edge.
  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++;
    if ({state, if_id_valid, fault, instruction_addr} !== {ST_BOOT, 1'b0, 1'b0, 10'h0}) begin
      failures++;
      $display("FAIL reset_ctrl: got state=%0d valid=%0b fault=%0b addr=%0h expected 0 0 0 0",
               state, if_id_valid, fault, instruction_addr);
    end
    checks++;
    if ({if_id_pc, if_id_pc_plus4, if_id_instr, fault_pc, fetch_count} !== 160'h0) begin
      failures++;
      $display("FAIL reset_regs: got pc=%0h pc4=%0h instr=%0h fpc=%0h cnt=%0h expected all 0",
               if_id_pc, if_id_pc_plus4, if_id_instr, fault_pc, fetch_count);
    end
    clear_inputs();
    sb.delete();
    exp_pc = 32'h0; exp_count = 32'h0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_sequential();
    tick(0, 0, ST_RUN);
    for (int i = 0; i < 3; i++) tick(1, 1, ST_RUN);
  endtask

  task automatic test_stall_redirect();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h40;
    exp_pc = 32'h40;
    tick(0, 0, ST_RUN);
    check_ifid_pc(32'h8);
    clear_inputs();
    tick(1, 1, ST_RUN);
  endtask

  task automatic test_stall_flush();
    redirect_valid = 1; redirect_pc = 32'h20; exp_pc = 32'h20;
    tick(0, 0, ST_RUN);
    clear_inputs();
    tick(1, 1, ST_RUN);
    stall = 1;
    tick(0, 1, ST_RUN);
    check_ifid_pc(32'h20);
    stall = 0; redirect_valid = 1; redirect_pc = 32'h20; exp_pc = 32'h20;
    tick(0, 0, ST_RUN);
    redirect_valid = 0; stall = 1; flush = 1;
    tick(0, 0, ST_RUN);
    stall = 0;
    exp_pc = 32'h24;
    tick(0, 0, ST_RUN);
    check_ifid_pc(32'h20);
    clear_inputs();
    tick(1, 1, ST_RUN);
  endtask

  task automatic test_halt_resume();
    halt_req = 1;
    tick(0, 0, ST_HALT);
    halt_req = 0; redirect_valid = 1; redirect_pc = 32'h100; exp_pc = 32'h100;
    tick(0, 0, ST_HALT);
    redirect_valid = 0; halt_req = 1; resume = 1;
    tick(0, 0, ST_HALT);
    halt_req = 0;
    tick(0, 0, ST_RUN);
    clear_inputs();
    tick(1, 1, ST_RUN);
    tick(1, 1, ST_RUN);
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFC; exp_pc = 32'hFFC;
    tick(0, 0, ST_RUN);
    clear_inputs();
    tick(1, 1, ST_RUN);
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; exp_pc = 32'hFFFF_FFFC;
    tick(0, 0, ST_RUN);
    clear_inputs();
    tick(1, 1, ST_RUN);
    tick(1, 1, ST_RUN);
  endtask

  task automatic test_misaligned();
    stall = 1; redirect_valid = 1; redirect_pc = 32'h42;
    tick(0, 0, ST_FAULT);
    checks++;
    if ({fault, fault_pc} !== {1'b1, 32'h42}) begin
      failures++; $display("FAIL fault_latch: got fault=%0b pc=%0h expected 1 42", fault, fault_pc);
    end
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom); flush = 1'($urandom); halt_req = 1'($urandom); resume = 1'($urandom);
      redirect_valid = 1; redirect_pc = (i % 2 == 0) ? 32'h80 : 32'h8A;
      tick(0, 0, ST_FAULT);
    end
    checks++;
    if ({fault, fault_pc} !== {1'b1, 32'h42}) begin
      failures++; $display("FAIL fault_sticky: got fault=%0b pc=%0h expected 1 42", fault, fault_pc);
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    checks++;
    if (state !== ST_BOOT) begin
      failures++; $display("FAIL boot_state: got %0d expected 0", state);
    end
    test_sequential();
    test_stall_redirect();
    test_stall_flush();
    test_halt_resume();
    test_wrap();
    test_misaligned();
    test_reset();
    test_sequential();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL provide these ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instruction_addr  out  10  word address to the instruction memory; equals pc[11:2]
- instruction  in  32  combinational read data from the instruction memory
- stall  in  1  hold PC and the IF/ID register
- flush  in  1  insert a bubble into IF/ID
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  target PC
- halt_req  in  1  stop fetching
- resume  in  1  restart fetching from HALTED
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_pc  out  32  PC of the IF/ID instruction
- if_id_pc_plus4  out  32  if_id_pc + 4
- if_id_instr  out  32  fetched instruction word
- state  out  2  BOOT=0, RUN=1, HALTED=2, FAULT=3
- fault  out  1  misaligned redirect detected
- fault_pc  out  32  offending redirect_pc
- fetch_count  out  32  count of instructions loaded into IF/ID with valid=1

Function
REQ-004 The block SHALL drive instruction_addr combinationally as pc[11:2]; the 10-bit address wraps naturally at 1024 words.
REQ-005 BOOT SHALL last exactly one cycle after reset release: pc is held, if_id_valid=0, and the next state is RUN.
REQ-006 In RUN with no stall, flush or redirect, each clock SHALL load IF/ID with {1, pc, pc+4, instruction} and set pc to pc+4, which wraps modulo 2^32.
REQ-007 In RUN with stall=1 and neither redirect nor flush, pc and all IF/ID fields SHALL hold.
REQ-008 When redirect_valid=1 with redirect_pc[1:0]=0, pc SHALL load redirect_pc and if_id_valid SHALL load 0, regardless of stall.
REQ-009 When flush=1 without redirect, if_id_valid SHALL load 0; pc advances by 4 unless stall=1, in which case pc holds.
REQ-010 Priority SHALL be: misaligned redirect > aligned redirect > flush > stall > normal fetch.
REQ-011 When redirect_valid=1 with redirect_pc[1:0]!=0 in any state except FAULT, the block SHALL:
- enter FAULT on the next edge
- set fault=1
- latch fault_pc=redirect_pc
- set if_id_valid=0
- hold pc
REQ-012 FAULT SHALL be left only by reset; in FAULT, all inputs except rst_n SHALL be ignored and if_id_valid SHALL stay 0.
REQ-013 halt_req=1 in RUN SHALL cause entry to HALTED on the next edge with if_id_valid=0 and pc held; no instruction is loaded on that edge.
REQ-014 In HALTED, if_id_valid SHALL stay 0 and pc SHALL hold, except that an aligned redirect SHALL update pc while the state remains HALTED.
REQ-015 In HALTED, resume=1 with halt_req=0 SHALL return to RUN on the next edge; if halt_req=1 and resume=1 together, halt_req SHALL win.
REQ-016 if_id_pc, if_id_pc_plus4 and if_id_instr SHALL hold their last values whenever if_id_valid loads 0.
REQ-017 fetch_count SHALL increment by 1 on every edge that loads if_id_valid=1 and SHALL wrap modulo 2^32.

Reset
REQ-018 On rst_n=0, asynchronously, the block SHALL set:
- pc=RESET_PC
- state=BOOT
- if_id_valid=0
- if_id_pc=0, if_id_pc_plus4=0, if_id_instr=0
- fault=0, fault_pc=0
- fetch_count=0
REQ-019 Reset asserted mid-operation, including in FAULT or HALTED, SHALL produce the REQ-018 values immediately, without waiting for a clock edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Sequential fetch: release reset with RESET_PC=0 and run 4 cycles -> BOOT for 1 cycle; then if_id_pc = 0, 4, 8, with instruction_addr = 0, 1, 2, 3; fetch_count=3.
- Stall plus redirect: stall=1 with redirect_valid=1 and redirect_pc=0x40 -> next cycle pc=0x40, instruction_addr=0x10, if_id_valid=0.
- Flush under stall: stall=1 and flush=1 with pc=0x20 -> pc stays 0x20, if_id_valid=0.
- Misaligned redirect: redirect_pc=0x42 -> state=3, fault=1, fault_pc=0x42; later stimulus has no effect until rst_n=0.
- Halt and resume: halt_req in RUN gives state=2; aligned redirect to 0x100 keeps state=2 with pc=0x100; resume gives RUN with next if_id_pc=0x100.
- Wrap: pc=0xFFC gives instruction_addr=0x3FF, then pc=0x1000 gives instruction_addr=0x000; pc=0xFFFF_FFFC gives if_id_pc_plus4=0.
